// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
// Weighted arbiter that drains two upstream virtual-channel FIFOs (VC0, VC1)
// into two destination FIFOs (D0, D1). VC0 is preferred, but VC1 is served
// after VC0_WEIGHT consecutive VC0 grants while VC1 has data waiting. Each
// popped word goes to D1 when word[DEST_BIT] is set, otherwise to D0. The
// push happens exactly one cycle after the pop.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | nothing popped, nothing in flight
// ACTIVE | a pop was issued or a word is in flight
// STALL  | destination backpressure while a VC still holds data
// ERROR  | a push hit a full destination; sticky until reset
//
// Ports
//   clk, reset                      clock, synchronous active-low reset
//   vc0_empty, vc1_empty            upstream FIFO empty flags
//   vc0_data, vc1_data              upstream read data (valid cycle after pop)
//   d0_full, d0_almost_full,
//   d1_full, d1_almost_full         destination FIFO flags
//   vc0_pop, vc1_pop                upstream read enables
//   d0_push, d1_push                destination write enables
//   d0_data, d1_data                destination write data (0 when no push)
//   state_out                       registered FSM state
//   error_out                       sticky overflow error
// -----------------------------------------------------------------------------
module vc_arbiter #(
    parameter int data_width = 6,
    parameter int DEST_BIT   = 5,
    parameter int VC0_WEIGHT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [data_width-1:0] vc0_data,
    input  logic [data_width-1:0] vc1_data,
    input  logic                  d0_full,
    input  logic                  d0_almost_full,
    input  logic                  d1_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [data_width-1:0] d0_data,
    output logic [data_width-1:0] d1_data,
    output logic [1:0]            state_out,
    output logic                  error_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [3:0] WEIGHT = 4'(VC0_WEIGHT);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_w_cnt;
    logic                  r_inflight_vld;
    logic                  r_inflight_sel;

    logic                  w_bp;
    logic                  w_pop_ok;
    logic                  w_vc0_pop;
    logic                  w_vc1_pop;
    logic                  w_push_ok;
    logic                  w_d0_push;
    logic                  w_d1_push;
    logic [data_width-1:0] w_word;

    assign w_bp = d0_full | d0_almost_full | d1_full | d1_almost_full;

    // The reset term keeps every strobe quiet while reset is held, even
    // before the first reset edge has cleared the registers.
    assign w_pop_ok  = reset && !w_bp && (r_state != ERROR);
    assign w_vc1_pop = w_pop_ok && !vc1_empty && (vc0_empty || (r_w_cnt == WEIGHT));
    assign w_vc0_pop = w_pop_ok && !vc0_empty && !w_vc1_pop;

    // Push depends only on registered grant info and the returned word, never
    // on destination flags: a word already popped must always land.
    assign w_word    = r_inflight_sel ? vc1_data : vc0_data;
    assign w_push_ok = reset && r_inflight_vld && (r_state != ERROR);
    assign w_d1_push = w_push_ok && w_word[DEST_BIT];
    assign w_d0_push = w_push_ok && !w_word[DEST_BIT];

    assign vc0_pop   = w_vc0_pop;
    assign vc1_pop   = w_vc1_pop;
    assign d0_push   = w_d0_push;
    assign d1_push   = w_d1_push;
    assign d0_data   = w_d0_push ? w_word : '0;
    assign d1_data   = w_d1_push ? w_word : '0;
    assign state_out = r_state;
    assign error_out = reset && (r_state == ERROR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_w_cnt        <= 4'd0;
            r_inflight_vld <= 1'b0;
            r_inflight_sel <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_inflight_vld <= w_vc0_pop | w_vc1_pop;
            r_inflight_sel <= w_vc1_pop;
            if (w_vc1_pop || vc1_empty) begin
                r_w_cnt <= 4'd0;
            end else if (w_vc0_pop) begin
                r_w_cnt <= r_w_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_next = IDLE;
        if ((r_state == ERROR) || (w_d0_push && d0_full) || (w_d1_push && d1_full)) begin
            w_state_next = ERROR;
        end else if (w_bp && (!vc0_empty || !vc1_empty)) begin
            w_state_next = STALL;
        end else if (w_vc0_pop || w_vc1_pop || r_inflight_vld) begin
            w_state_next = ACTIVE;
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
module tb_vc_arbiter;

    localparam int DW = 6;
    localparam int DB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          vc0_empty, vc1_empty;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          d0_full, d0_almost_full, d1_full, d1_almost_full;
    logic          vc0_pop, vc1_pop, d0_push, d1_push;
    logic [DW-1:0] d0_data, d1_data;
    logic [1:0]    state_out;
    logic          error_out;

    vc_arbiter #(.data_width(DW), .DEST_BIT(DB), .VC0_WEIGHT(4)) dut (
        .clk(clk), .reset(reset),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_full(d0_full), .d0_almost_full(d0_almost_full),
        .d1_full(d1_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_push(d0_push), .d1_push(d1_push),
        .d0_data(d0_data), .d1_data(d1_data),
        .state_out(state_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        dest;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic [1:0] load;   // 0 none, 1 VC0 <= 01,02,03, 2 VC1 <= 21,22,23
        logic [3:0] flags;  // {d1_full, d1_af, d0_full, d0_af}
        logic       ep0;
        logic       ep1;
        logic [1:0] est;
    } vec_t;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    sb_t           sb[$];
    logic          glog[$];
    vec_t          vt[15];

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    logic exp_err  = 1'b0;
    logic s_p0, s_p1, s_err;
    logic [1:0] s_state;
    logic [3:0] s_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        {d1_full, d1_almost_full, d0_full, d0_almost_full} = f;
    endtask

    task automatic set_empties();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
    endtask

    // One clock cycle of the environment: sample at the falling edge, check
    // pushes against the scoreboard, model the upstream FIFOs, then drive the
    // next cycle's inputs just after the rising edge.
    task automatic tick();
        logic          p0, p1, e0, e1;
        logic [DW-1:0] w, ed0, ed1;
        sb_t           ent;
        w = '0; e0 = 0; e1 = 0; ed0 = '0; ed1 = '0;
        @(negedge clk);
        p0 = vc0_pop; p1 = vc1_pop;
        s_p0 = p0; s_p1 = p1; s_state = state_out; s_err = error_out;
        s_cnt = dut.r_w_cnt;
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
            check("rst_outs", 32'({p0, p1, d0_push, d1_push, d0_data, d1_data, error_out}), 32'd0);
        end else begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                ent = sb.pop_front();
                if (ent.dest) begin e1 = 1; ed1 = ent.data; end
                else          begin e0 = 1; ed0 = ent.data; end
            end
            check("push", 32'({d0_push, d1_push, d0_data, d1_data}), 32'({e0, e1, ed0, ed1}));
            check("pop_excl", 32'(p0 & p1), 32'd0);
            if ({d1_full, d1_almost_full, d0_full, d0_almost_full} != 4'd0 || exp_err)
                check("pop_block", 32'({p0, p1}), 32'd0);
        end
        if (p0 || p1) begin
            if (p0 && q0.size() > 0) w = q0.pop_front();
            else if (p1 && q1.size() > 0) w = q1.pop_front();
            else check("pop_empty", 32'({p0, p1}), 32'd0);
            glog.push_back(p1);
            if (reset && !exp_err) sb.push_back('{cyc + 1, w[DB], w});
        end
        @(posedge clk);
        #1;
        vc0_data = p0 ? w : '0;
        vc1_data = p1 ? w : '0;
        set_empties();
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        check("drain_done", 32'(q0.size() + q1.size() + sb.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic exp_order[12];
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};

        // three VC0 words to D0, then the backpressure/STALL sequence on VC1
        vt[0]  = '{1, 4'b0000, 1, 0, 2'd0};
        vt[1]  = '{0, 4'b0000, 1, 0, 2'd1};
        vt[2]  = '{0, 4'b0000, 1, 0, 2'd1};
        vt[3]  = '{0, 4'b0000, 0, 0, 2'd1};
        vt[4]  = '{0, 4'b0000, 0, 0, 2'd1};
        vt[5]  = '{0, 4'b0000, 0, 0, 2'd0};
        vt[6]  = '{2, 4'b0000, 0, 1, 2'd0};
        vt[7]  = '{0, 4'b0100, 0, 0, 2'd1};
        vt[8]  = '{0, 4'b0100, 0, 0, 2'd2};
        vt[9]  = '{0, 4'b0100, 0, 0, 2'd2};
        vt[10] = '{0, 4'b0000, 0, 1, 2'd2};
        vt[11] = '{0, 4'b0000, 0, 1, 2'd1};
        vt[12] = '{0, 4'b0000, 0, 0, 2'd1};
        vt[13] = '{0, 4'b0000, 0, 0, 2'd1};
        vt[14] = '{0, 4'b0000, 0, 0, 2'd0};

        reset = 1'b0;
        vc0_data = '0; vc1_data = '0;
        set_flags(4'd0);
        set_empties();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_state", 32'(s_state), 32'd0);
        check("reset_err", 32'(s_err), 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (vt[i].load == 2'd1) begin q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03); end
            if (vt[i].load == 2'd2) begin q1.push_back(6'h21); q1.push_back(6'h22); q1.push_back(6'h23); end
            set_empties();
            set_flags(vt[i].flags);
            tick();
            check($sformatf("vec%0d_pops", i), 32'({s_p0, s_p1}), 32'({vt[i].ep0, vt[i].ep1}));
            check($sformatf("vec%0d_state", i), 32'(s_state), 32'(vt[i].est));
        end

        // alternating destinations from VC0
        q0.push_back(6'h10); q0.push_back(6'h30); q0.push_back(6'h10); q0.push_back(6'h30);
        set_empties();
        drain();

        // weighted grant order with both VCs loaded
        glog.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(6'(i + 1));
            q1.push_back(6'(6'h21 + i));
        end
        set_empties();
        drain();
        check("grant_count", 32'(glog.size()), 32'd12);
        for (int i = 0; i < 12 && i < glog.size(); i++)
            check($sformatf("grant%0d", i), 32'(glog[i]), 32'(exp_order[i]));

        // reset in the cycle after a pop drops the in-flight word
        q0.push_back(6'h07); q0.push_back(6'h08); q1.push_back(6'h29);
        set_empties();
        tick();
        check("rstmid_pop", 32'({s_p0, s_p1}), 32'b10);
        reset = 1'b0;
        tick();
        check("rstmid_cnt_before", 32'(s_cnt), 32'd1);
        reset = 1'b1;
        tick();
        check("rstmid_state", 32'(s_state), 32'd0);
        check("rstmid_cnt", 32'(s_cnt), 32'd0);
        drain();

        // destination full while a D0 word is in flight
        q0.push_back(6'h05);
        set_empties();
        tick();
        check("err_pop", 32'({s_p0, s_p1}), 32'b10);
        set_flags(4'b0010);
        tick();
        exp_err = 1'b1;
        set_flags(4'd0);
        q0.push_back(6'h01); q0.push_back(6'h02); q1.push_back(6'h21);
        set_empties();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("err_state", 32'(s_state), 32'd3);
            check("err_flag", 32'(s_err), 32'd1);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_err = 1'b0;
        tick();
        check("err_cleared_state", 32'(s_state), 32'd0);
        check("err_cleared_flag", 32'(s_err), 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 SHALL have parameter data_width, default 6, width of every data port.
REQ-002 SHALL have parameter DEST_BIT, default 5, data bit that selects the destination (0 = D0, 1 = D1).
REQ-003 SHALL have parameter VC0_WEIGHT, default 4, legal 1..15: maximum consecutive VC0 grants while VC1 holds data.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports vc0_empty, vc1_empty  input  1 each  upstream VC FIFO empty flags.
REQ-007 SHALL have ports vc0_data, vc1_data  input  data_width each  upstream FIFO read data, valid the cycle after a pop, zero otherwise.
REQ-008 SHALL have ports d0_full, d0_almost_full, d1_full, d1_almost_full  input  1 each  destination FIFO flags.
REQ-009 SHALL have ports vc0_pop, vc1_pop  output  1 each  read enables to the VC FIFOs.
REQ-010 SHALL have ports d0_push, d1_push  output  1 each  write enables to the destination FIFOs.
REQ-011 SHALL have ports d0_data, d1_data  output  data_width each  write data to the destination FIFOs.
REQ-012 SHALL have port state_out  output  2  registered FSM state: IDLE=0, ACTIVE=1, STALL=2, ERROR=3.
REQ-013 SHALL have port error_out  output  1  sticky overflow error, high exactly when state_out == ERROR.

Function
REQ-014 SHALL define backpressure bp = d0_full | d0_almost_full | d1_full | d1_almost_full.
REQ-015 SHALL issue at most one pop per cycle; a pop is allowed only when bp = 0 and state is not ERROR.
REQ-016 SHALL decide pops combinationally from the current-cycle empty and bp flags.
REQ-017 SHALL assert vc1_pop when allowed, vc1_empty = 0, and either vc0_empty = 1 or w_cnt == VC0_WEIGHT.
REQ-018 SHALL otherwise assert vc0_pop when allowed and vc0_empty = 0.
REQ-019 SHALL keep a 4-bit counter w_cnt: increment on a VC0 grant while vc1_empty = 0, clear on any VC1 grant, clear on any cycle with vc1_empty = 1, hold otherwise.
REQ-020 SHALL register the grant: inflight_vld = pop issued, inflight_sel = 1 if VC1 was granted.
REQ-021 SHALL, in the cycle after a pop (inflight_vld = 1), take word w from vc1_data if inflight_sel = 1, else from vc0_data.
REQ-022 SHALL, in that same cycle, combinationally assert d1_push with d1_data = w if w[DEST_BIT] = 1, else d0_push with d0_data = w. Pop-to-push latency is exactly 1 cycle.
REQ-023 SHALL drive d0_data and d1_data to 0, and both pushes low, whenever the corresponding push is not asserted.
REQ-024 SHALL never assert d0_push and d1_push in the same cycle, nor vc0_pop and vc1_pop in the same cycle.
REQ-025 SHALL register the next state with this priority:
  - ERROR if already ERROR, or if a push targets a destination whose full = 1;
  - else STALL if bp = 1 and either VC is non-empty;
  - else ACTIVE if a pop is issued or inflight_vld = 1;
  - else IDLE.
REQ-026 SHALL still complete a push for a word already in flight when bp rises; with at most one word in flight, no destination overflows.
REQ-027 SHALL, in ERROR, suppress all pops, complete no further pushes, and stay in ERROR until reset.
REQ-028 SHALL contain no combinational path from d*_full or d*_almost_full to d*_push.

Reset
REQ-029 SHALL, while reset = 0 at a clock edge, set state to IDLE, w_cnt = 0 and inflight_vld = 0.
REQ-030 SHALL hold all pops, pushes, data outputs and error_out at 0 during reset, including mid-transfer; an in-flight word is dropped.

Verification
REQ-031 SHALL cover this scenario: VC0 holds 3 words with DEST_BIT = 0 (0x01, 0x02, 0x03), VC1 empty, no bp -> vc0_pop for 3 cycles, d0_push the next 3 cycles with d0_data 0x01, 0x02, 0x03, state_out ACTIVE then IDLE.
REQ-032 SHALL cover this scenario: both VCs hold 6 words, VC0_WEIGHT = 4 -> grant order VC0 ×4, VC1, then VC0 ×2, VC1 × remaining.
REQ-033 SHALL cover this scenario: word 0x21 popped, d1_almost_full rises in the push cycle -> d1_push of 0x21 completes, no further pop, state_out = STALL; pops resume one cycle after bp clears.
REQ-034 SHALL cover this scenario: destination FIFO forced full while a word bound to it is in flight -> error_out = 1 next cycle, state_out = ERROR, no pops for 10 cycles, cleared only by reset.
REQ-035 SHALL cover this scenario: reset = 0 asserted in the cycle after a pop -> no push that cycle, all outputs 0, state_out = IDLE, w_cnt = 0.
REQ-036 SHALL cover this scenario: words 0x10 and 0x30 alternate from VC0 -> 0x10 pushed to D0 and 0x30 to D1, never both pushes high in one cycle.
